// File: rtl/burst_fetch.sv
// -----------------------------------------------------------------------------
// burst_fetch
//
// AXI4 read-burst fetch engine. It streams a contiguous, word-aligned memory
// region into the downstream byte FIFO that feeds the lexer. The region is
// fetched as INCR bursts of at most BURST_LEN beats. A burst never crosses a
// 4 KB page, and a burst is only requested once the FIFO reports enough free
// words to absorb all of its beats.
//
// Ports
//   CCLK, CRST          clock; asynchronous active-high reset
//   START               one-cycle pulse, accepted only in IDLE
//   ABORT               stop after the in-flight burst completes
//   BASE_ADDR, LENGTH   start byte address (low bits ignored), length in words
//   FIFO_SPACE          free words in the downstream FIFO
//   BUSY, DONE, ERR     status: in progress, end-of-transfer pulse,
//                       sticky error flag (cleared by START)
//   O_VALID/O_DATA/O_LAST
//                       output word stream, one cycle after each R beat
//   M_AXI_AR*, M_AXI_R* AXI4 read address and read data channels
// -----------------------------------------------------------------------------
module burst_fetch #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_LEN   = 16,
    parameter int LEN_WIDTH   = 24,
    parameter int SPACE_WIDTH = 12
) (
    input  logic                   CCLK,
    input  logic                   CRST,
    input  logic                   START,
    input  logic                   ABORT,
    input  logic [ADDR_WIDTH-1:0]  BASE_ADDR,
    input  logic [LEN_WIDTH-1:0]   LENGTH,
    input  logic [SPACE_WIDTH-1:0] FIFO_SPACE,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR,
    output logic                   O_VALID,
    output logic [DATA_WIDTH-1:0]  O_DATA,
    output logic                   O_LAST,
    output logic [ADDR_WIDTH-1:0]  M_AXI_ARADDR,
    output logic [7:0]             M_AXI_ARLEN,
    output logic [2:0]             M_AXI_ARSIZE,
    output logic [1:0]             M_AXI_ARBURST,
    output logic                   M_AXI_ARVALID,
    input  logic                   M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]  M_AXI_RDATA,
    input  logic [1:0]             M_AXI_RRESP,
    input  logic                   M_AXI_RLAST,
    input  logic                   M_AXI_RVALID,
    output logic                   M_AXI_RREADY
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    // Common width for comparing beat counts (<= 4096, 13 bits) against the
    // length and space registers without truncating either side.
    localparam int CW0   = (LEN_WIDTH > SPACE_WIDTH) ? LEN_WIDTH : SPACE_WIDTH;
    localparam int CW    = (CW0 > 13) ? CW0 : 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_AR,
        ST_R,
        ST_FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic                    err_q, err_d;
    logic                    abort_q, abort_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    o_valid_q, o_valid_d;
    logic                    o_last_q, o_last_d;
    logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;

    // Beats for the next burst: the smallest of the burst limit, the words
    // still owed, and the words left before the next 4 KB page boundary.
    // addr_q is word-aligned, so the page division is exact.
    logic [12:0] page_beats;
    logic [12:0] cap_beats;
    logic [12:0] beats;
    logic        space_ok;
    logic        beat;
    logic        rresp_bad;

    assign page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> LSB;
    assign cap_beats  = (page_beats < 13'(BURST_LEN)) ? page_beats : 13'(BURST_LEN);
    assign beats      = (CW'(remaining_q) < CW'(cap_beats)) ? 13'(remaining_q) : cap_beats;
    assign space_ok   = CW'(FIFO_SPACE) >= CW'(beats);
    assign beat       = M_AXI_RVALID & rready_q;
    assign rresp_bad  = M_AXI_RRESP != 2'b00;

    always_comb begin
        // NOTE: every *_d gets a default before the case statement, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        abort_d     = abort_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        o_valid_d   = 1'b0;
        o_last_d    = 1'b0;
        o_data_d    = o_data_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    addr_d      = BASE_ADDR & ~ADDR_WIDTH'(BYTES - 1);
                    remaining_d = LENGTH;
                    err_d       = 1'b0;
                    abort_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (LENGTH == '0) ? ST_FIN : ST_CALC;
                end
            end

            ST_CALC: begin
                // Nothing is outstanding on the bus here, so abort is immediate.
                if (ABORT) begin
                    state_d = ST_FIN;
                end else if (space_ok) begin
                    araddr_d  = addr_q;
                    arlen_d   = 8'(beats - 13'd1);
                    arvalid_d = 1'b1;
                    state_d   = ST_AR;
                end
            end

            ST_AR: begin
                if (ABORT) abort_d = 1'b1;
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end

            ST_R: begin
                if (ABORT) abort_d = 1'b1;
                if (beat) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    addr_d      = addr_q + ADDR_WIDTH'(BYTES);
                    // After the first bad response nothing more is forwarded,
                    // but beats are still accepted to finish the burst legally.
                    if (rresp_bad) begin
                        err_d = 1'b1;
                    end else if (!err_q) begin
                        o_valid_d = 1'b1;
                        o_data_d  = M_AXI_RDATA;
                        o_last_d  = (remaining_q == LEN_WIDTH'(1));
                    end
                    // An early RLAST simply ends the burst; remaining already
                    // reflects the beats actually received.
                    if (M_AXI_RLAST) begin
                        rready_d = 1'b0;
                        if (remaining_q == LEN_WIDTH'(1) || rresp_bad || err_q ||
                            abort_q || ABORT)
                            state_d = ST_FIN;
                        else
                            state_d = ST_CALC;
                    end
                end
            end

            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            o_valid_q   <= 1'b0;
            o_last_q    <= 1'b0;
            o_data_q    <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            o_valid_q   <= o_valid_d;
            o_last_q    <= o_last_d;
            o_data_q    <= o_data_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERR           = err_q;
    assign O_VALID       = o_valid_q;
    assign O_DATA        = o_data_q;
    assign O_LAST        = o_last_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = 3'(LSB);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_burst_fetch.sv
// -----------------------------------------------------------------------------
// tb_burst_fetch
//
// Directed bench for burst_fetch (32-bit data, 16-beat bursts). A small AXI
// read slave answers every accepted AR with an INCR burst whose data words are
// a fixed function of the beat address, so the expected output stream follows
// from the base address alone. A monitor logs AR handshakes, output words and
// DONE pulses on the falling edge; each test task compares those logs against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_burst_fetch;

    logic        CCLK;
    logic        CRST;
    logic        START;
    logic        ABORT;
    logic [31:0] BASE_ADDR;
    logic [23:0] LENGTH;
    logic [11:0] FIFO_SPACE;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic        O_VALID;
    logic [31:0] O_DATA;
    logic        O_LAST;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    burst_fetch #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BURST_LEN  (16),
        .LEN_WIDTH  (24),
        .SPACE_WIDTH(12)
    ) dut (
        .CCLK         (CCLK),
        .CRST         (CRST),
        .START        (START),
        .ABORT        (ABORT),
        .BASE_ADDR    (BASE_ADDR),
        .LENGTH       (LENGTH),
        .FIFO_SPACE   (FIFO_SPACE),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .ERR          (ERR),
        .O_VALID      (O_VALID),
        .O_DATA       (O_DATA),
        .O_LAST       (O_LAST),
        .M_AXI_ARADDR (M_AXI_ARADDR),
        .M_AXI_ARLEN  (M_AXI_ARLEN),
        .M_AXI_ARSIZE (M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA  (M_AXI_RDATA),
        .M_AXI_RRESP  (M_AXI_RRESP),
        .M_AXI_RLAST  (M_AXI_RLAST),
        .M_AXI_RVALID (M_AXI_RVALID),
        .M_AXI_RREADY (M_AXI_RREADY)
    );

    initial begin
        CCLK = 1'b0;
        forever #5 CCLK = ~CCLK;
    end

    int checks = 0;
    int errors = 0;

    // Logs written only by the monitor process.
    logic [31:0] out_data[$];
    bit          out_last[$];
    logic [31:0] ar_addr_log[$];
    logic [7:0]  ar_len_log[$];
    int          done_cnt = 0;
    int          r_beats_total = 0;

    // Absolute beat number that gets RRESP=SLVERR; written only by the tests.
    int          err_beat = -1;

    // Slave-private state.
    logic [31:0] bq_addr[$];
    logic [7:0]  bq_len[$];
    int          beat_idx = 0;
    bit          ar_hs;
    bit          r_hs;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Monitor on the falling edge, slave outputs updated just after the
    // rising edge.
    initial begin : slave_monitor
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
        M_AXI_RDATA  = '0;
        M_AXI_RRESP  = 2'b00;
        forever begin
            @(negedge CCLK);
            if (CRST) begin
                ar_hs = 1'b0;
                r_hs  = 1'b0;
            end else begin
                ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
                r_hs  = M_AXI_RVALID && M_AXI_RREADY;
                if (O_VALID) begin
                    out_data.push_back(O_DATA);
                    out_last.push_back(O_LAST);
                end
                if (DONE) done_cnt++;
                if (ar_hs) begin
                    ar_addr_log.push_back(M_AXI_ARADDR);
                    ar_len_log.push_back(M_AXI_ARLEN);
                end
                if (r_hs) r_beats_total++;
            end
            @(posedge CCLK);
            #1;
            if (CRST) begin
                bq_addr.delete();
                bq_len.delete();
                beat_idx = 0;
            end else begin
                if (r_hs) begin
                    beat_idx++;
                    if (beat_idx > int'(bq_len[0])) begin
                        void'(bq_addr.pop_front());
                        void'(bq_len.pop_front());
                        beat_idx = 0;
                    end
                end
                if (ar_hs) begin
                    bq_addr.push_back(M_AXI_ARADDR);
                    bq_len.push_back(M_AXI_ARLEN);
                end
            end
            if (!CRST && bq_addr.size() > 0) begin
                M_AXI_RVALID = 1'b1;
                M_AXI_RDATA  = word_of(bq_addr[0] + 32'(beat_idx * 4));
                M_AXI_RLAST  = (beat_idx == int'(bq_len[0]));
                M_AXI_RRESP  = (r_beats_total == err_beat) ? 2'b10 : 2'b00;
            end else begin
                M_AXI_RVALID = 1'b0;
                M_AXI_RLAST  = 1'b0;
                M_AXI_RRESP  = 2'b00;
            end
        end
    end

    task automatic start_xfer(input logic [31:0] base, input logic [23:0] len);
        @(posedge CCLK);
        #1;
        BASE_ADDR = base;
        LENGTH    = len;
        START     = 1'b1;
        @(posedge CCLK);
        #1;
        START     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge CCLK);
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_timeout: no DONE within %0d cycles", name, budget);
        end
        repeat (3) @(posedge CCLK);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({BUSY, DONE, ERR, O_VALID, O_LAST, M_AXI_ARVALID, M_AXI_RREADY} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {BUSY, DONE, ERR, O_VALID, O_LAST, M_AXI_ARVALID, M_AXI_RREADY});
        end
        checks++;
        if (M_AXI_ARADDR !== 32'h0 || M_AXI_ARLEN !== 8'h0 || O_DATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: araddr %h arlen %h odata %h want zeros",
                     M_AXI_ARADDR, M_AXI_ARLEN, O_DATA);
        end
        checks++;
        if (M_AXI_ARSIZE !== 3'd2 || M_AXI_ARBURST !== 2'b01) begin
            errors++;
            $display("FAIL reset_const: arsize %0d arburst %b want 2 01",
                     M_AXI_ARSIZE, M_AXI_ARBURST);
        end
        @(posedge CCLK);
        #2;
        CRST = 1'b0;
    endtask

    task automatic test_multi_burst;
        logic [31:0] exp_addr[3] = '{32'h1000, 32'h1040, 32'h1080};
        logic [7:0]  exp_len[3]  = '{8'd15, 8'd15, 8'd7};
        int a0 = ar_addr_log.size();
        int o0 = out_data.size();
        int d0 = done_cnt;
        start_xfer(32'h1000, 24'd40);
        // A second START mid-transfer must be ignored.
        repeat (10) @(posedge CCLK);
        start_xfer(32'h9000, 24'd1);
        wait_done(d0, 300, "t1");
        checks++;
        if (ar_addr_log.size() - a0 != 3) begin
            errors++;
            $display("FAIL t1_ar_count: got %0d want 3", ar_addr_log.size() - a0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a0 + i >= ar_addr_log.size() || ar_addr_log[a0+i] !== exp_addr[i] ||
                ar_len_log[a0+i] !== exp_len[i]) begin
                errors++;
                $display("FAIL t1_ar[%0d]: got %h/%0d want %h/%0d", i,
                         ar_addr_log[a0+i], ar_len_log[a0+i], exp_addr[i], exp_len[i]);
            end
        end
        checks++;
        if (out_data.size() - o0 != 40) begin
            errors++;
            $display("FAIL t1_word_count: got %0d want 40", out_data.size() - o0);
        end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w = word_of(32'h1000 + 32'(4 * i));
            checks++;
            if (o0 + i >= out_data.size() || out_data[o0+i] !== w ||
                out_last[o0+i] != (i == 39)) begin
                errors++;
                $display("FAIL t1_word[%0d]: got %h last %0b want %h last %0b", i,
                         out_data[o0+i], out_last[o0+i], w, (i == 39));
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || ERR !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL t1_status: dones %0d err %b busy %b want 1 0 0",
                     done_cnt - d0, ERR, BUSY);
        end
    endtask

    task automatic test_page_split;
        int a0 = ar_addr_log.size();
        int o0 = out_data.size();
        int d0 = done_cnt;
        start_xfer(32'h0FF8, 24'd10);
        wait_done(d0, 200, "t2");
        checks++;
        if (ar_addr_log.size() - a0 != 2 || ar_addr_log[a0] !== 32'h0FF8 ||
            ar_len_log[a0] !== 8'd1 || ar_addr_log[a0+1] !== 32'h1000 ||
            ar_len_log[a0+1] !== 8'd7) begin
            errors++;
            $display("FAIL t2_ars: got %0d ARs %h/%0d %h/%0d want 2 ARs 0ff8/1 1000/7",
                     ar_addr_log.size() - a0, ar_addr_log[a0], ar_len_log[a0],
                     ar_addr_log[a0+1], ar_len_log[a0+1]);
        end
        checks++;
        if (out_data.size() - o0 != 10) begin
            errors++;
            $display("FAIL t2_word_count: got %0d want 10", out_data.size() - o0);
        end
        for (int i = 0; i < 10; i++) begin
            logic [31:0] w = word_of(32'h0FF8 + 32'(4 * i));
            checks++;
            if (o0 + i >= out_data.size() || out_data[o0+i] !== w ||
                out_last[o0+i] != (i == 9)) begin
                errors++;
                $display("FAIL t2_word[%0d]: got %h last %0b want %h last %0b", i,
                         out_data[o0+i], out_last[o0+i], w, (i == 9));
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL t2_done: got %0d pulses want 1", done_cnt - d0);
        end
    endtask

    task automatic test_space_gate;
        int  a0 = ar_addr_log.size();
        int  o0 = out_data.size();
        int  d0 = done_cnt;
        bit  saw = 1'b0;
        FIFO_SPACE = 12'd5;
        start_xfer(32'h2000, 24'd16);
        repeat (20) begin
            @(negedge CCLK);
            if (M_AXI_ARVALID) saw = 1'b1;
        end
        checks++;
        if (saw || ar_addr_log.size() != a0) begin
            errors++;
            $display("FAIL t3_gated: arvalid seen %0b ars %0d want 0 0",
                     saw, ar_addr_log.size() - a0);
        end
        @(posedge CCLK);
        #1;
        FIFO_SPACE = 12'd16;
        @(negedge CCLK);
        checks++;
        if (M_AXI_ARVALID !== 1'b0) begin
            errors++;
            $display("FAIL t3_arvalid_early: got %b want 0", M_AXI_ARVALID);
        end
        @(negedge CCLK);
        checks++;
        if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 32'h2000 || M_AXI_ARLEN !== 8'd15) begin
            errors++;
            $display("FAIL t3_ar: got valid %b %h/%0d want 1 2000/15",
                     M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN);
        end
        wait_done(d0, 200, "t3");
        checks++;
        if (out_data.size() - o0 != 16) begin
            errors++;
            $display("FAIL t3_word_count: got %0d want 16", out_data.size() - o0);
        end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w = word_of(32'h2000 + 32'(4 * i));
            checks++;
            if (o0 + i >= out_data.size() || out_data[o0+i] !== w ||
                out_last[o0+i] != (i == 15)) begin
                errors++;
                $display("FAIL t3_word[%0d]: got %h last %0b want %h last %0b", i,
                         out_data[o0+i], out_last[o0+i], w, (i == 15));
            end
        end
        FIFO_SPACE = 12'd1024;
    endtask

    task automatic test_error;
        int a0  = ar_addr_log.size();
        int o0  = out_data.size();
        int d0  = done_cnt;
        int rb0 = r_beats_total;
        bit any_last = 1'b0;
        err_beat = rb0 + 3;
        start_xfer(32'h3000, 24'd16);
        wait_done(d0, 200, "t4");
        err_beat = -1;
        checks++;
        if (out_data.size() - o0 != 3) begin
            errors++;
            $display("FAIL t4_word_count: got %0d want 3", out_data.size() - o0);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] w = word_of(32'h3000 + 32'(4 * i));
            checks++;
            if (o0 + i >= out_data.size() || out_data[o0+i] !== w) begin
                errors++;
                $display("FAIL t4_word[%0d]: got %h want %h", i, out_data[o0+i], w);
            end
        end
        for (int i = o0; i < out_data.size(); i++) any_last |= out_last[i];
        checks++;
        if (any_last || ERR !== 1'b1) begin
            errors++;
            $display("FAIL t4_err: o_last seen %0b err %b want 0 1", any_last, ERR);
        end
        checks++;
        if (r_beats_total - rb0 != 16 || ar_addr_log.size() - a0 != 1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL t4_accept: beats %0d ars %0d dones %0d want 16 1 1",
                     r_beats_total - rb0, ar_addr_log.size() - a0, done_cnt - d0);
        end
    endtask

    task automatic test_abort;
        int a0  = ar_addr_log.size();
        int o0  = out_data.size();
        int d0  = done_cnt;
        int rb0 = r_beats_total;
        int n   = 0;
        bit any_last = 1'b0;
        start_xfer(32'h4000, 24'd48);
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL t5_err_clear: got %b want 0", ERR);
        end
        while (r_beats_total < rb0 + 5 && n < 100) begin
            @(posedge CCLK);
            n++;
        end
        #1;
        ABORT = 1'b1;
        @(posedge CCLK);
        #1;
        ABORT = 1'b0;
        wait_done(d0, 200, "t5");
        for (int i = o0; i < out_data.size(); i++) any_last |= out_last[i];
        checks++;
        if (out_data.size() - o0 != 16 || any_last) begin
            errors++;
            $display("FAIL t5_words: got %0d last seen %0b want 16 0",
                     out_data.size() - o0, any_last);
        end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w = word_of(32'h4000 + 32'(4 * i));
            checks++;
            if (o0 + i >= out_data.size() || out_data[o0+i] !== w) begin
                errors++;
                $display("FAIL t5_word[%0d]: got %h want %h", i, out_data[o0+i], w);
            end
        end
        checks++;
        if (ar_addr_log.size() - a0 != 1 || done_cnt - d0 != 1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL t5_status: ars %0d dones %0d busy %b want 1 1 0",
                     ar_addr_log.size() - a0, done_cnt - d0, BUSY);
        end

        // Zero-length transfer: IDLE -> FIN -> IDLE, DONE two cycles after START.
        a0 = ar_addr_log.size();
        start_xfer(32'h7000, 24'd0);
        @(negedge CCLK);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL t5_len0_c1: done %b busy %b want 0 1", DONE, BUSY);
        end
        @(negedge CCLK);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL t5_len0_c2: done %b busy %b want 1 0", DONE, BUSY);
        end
        @(negedge CCLK);
        checks++;
        if (DONE !== 1'b0 || ar_addr_log.size() != a0) begin
            errors++;
            $display("FAIL t5_len0_c3: done %b ars %0d want 0 0", DONE, ar_addr_log.size() - a0);
        end
    endtask

    task automatic test_reset_mid;
        int o0 = out_data.size();
        int a0;
        int d0;
        int n  = 0;
        start_xfer(32'h5000, 24'd16);
        while (out_data.size() < o0 + 3 && n < 100) begin
            @(posedge CCLK);
            n++;
        end
        #2;
        checks++;
        if (M_AXI_RREADY !== 1'b1 || BUSY !== 1'b1 || O_VALID !== 1'b1) begin
            errors++;
            $display("FAIL t6_pre: rready %b busy %b ovalid %b want 1 1 1",
                     M_AXI_RREADY, BUSY, O_VALID);
        end
        #1;
        CRST = 1'b1;
        #1;
        checks++;
        if (BUSY !== 1'b0 || O_VALID !== 1'b0 || M_AXI_RREADY !== 1'b0) begin
            errors++;
            $display("FAIL t6_async: busy %b ovalid %b rready %b want 0 0 0",
                     BUSY, O_VALID, M_AXI_RREADY);
        end
        repeat (2) @(posedge CCLK);
        #2;
        CRST = 1'b0;
        a0 = ar_addr_log.size();
        o0 = out_data.size();
        d0 = done_cnt;
        start_xfer(32'h6000, 24'd4);
        wait_done(d0, 100, "t6");
        checks++;
        if (ar_addr_log.size() - a0 != 1 || ar_addr_log[a0] !== 32'h6000 || ar_len_log[a0] !== 8'd3) begin
            errors++;
            $display("FAIL t6_ar: got %0d ARs %h/%0d want 1 AR 6000/3",
                     ar_addr_log.size() - a0, ar_addr_log[a0], ar_len_log[a0]);
        end
        checks++;
        if (out_data.size() - o0 != 4) begin
            errors++;
            $display("FAIL t6_word_count: got %0d want 4", out_data.size() - o0);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w = word_of(32'h6000 + 32'(4 * i));
            checks++;
            if (o0 + i >= out_data.size() || out_data[o0+i] !== w ||
                out_last[o0+i] != (i == 3)) begin
                errors++;
                $display("FAIL t6_word[%0d]: got %h last %0b want %h last %0b", i,
                         out_data[o0+i], out_last[o0+i], w, (i == 3));
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CRST          = 1'b1;
        START         = 1'b0;
        ABORT         = 1'b0;
        BASE_ADDR     = '0;
        LENGTH        = '0;
        FIFO_SPACE    = 12'd1024;
        M_AXI_ARREADY = 1'b1;

        test_reset();
        test_multi_burst();
        test_page_split();
        test_space_gate();
        test_error();
        test_abort();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
